iterative_alu: RTL and testbench
================================

ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the operand and result width; only 32 is required to be supported.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on the rising edge.
REQ-003 The block SHALL have port reset, input, 1, with synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, which indicates that a request is present.
REQ-005 The block SHALL have port in_ready, output, 1, which indicates that the block can accept a request.
REQ-006 The block SHALL have port Operation, input, 4, carrying the operation code defined in REQ-012.
REQ-007 The block SHALL have ports SrcA and SrcB, input, 32 each, carrying the operands.
REQ-008 The block SHALL have port out_valid, output, 1, which indicates that a result is present.
REQ-009 The block SHALL have port out_ready, input, 1, by which the consumer accepts the result.
REQ-010 The block SHALL have port ALUResult, output, 32, the registered result.
REQ-011 The block SHALL have port Zero, output, 1, equal to (ALUResult == 0).

Function
REQ-012 Operation codes SHALL map as follows:
- 0000 AND
- 0001 SUB
- 0010 ADD
- 0011 OR
- 0100 XOR
- 0101 SLT: signed compare; result is 1 if A < B, else 0.
- 1000 EQUAL: result is 1 if A == B, else 0.
- 1001 SLL
- 1010 SRL
- 1011 SRA
- All other codes: result 0.
REQ-013 ADD and SUB SHALL wrap modulo 2^32; no carry or overflow output.
REQ-014 SLT and EQUAL results SHALL be zero-extended to 32 bits.
REQ-015 The shift amount SHALL be SrcB[4:0]; SrcB[31:5] SHALL be ignored.
REQ-016 SRA SHALL fill vacated bits with the sign bit of SrcA; SLL and SRL SHALL fill with 0.
REQ-017 The FSM SHALL have exactly three states:
- IDLE
- SHIFT
- DONE
REQ-018 in_ready SHALL be 1 exactly when the state is IDLE.
REQ-019 A request SHALL be accepted on a rising edge where in_valid && in_ready; Operation, SrcA and SrcB SHALL be sampled only at that edge, and later changes SHALL be ignored.
REQ-020 On acceptance of a non-shift op, or of a shift with amount 0, the block SHALL load ALUResult and enter DONE, giving a latency of 1 cycle.
REQ-021 On acceptance of a shift with amount N > 0, the block SHALL load the shift register with SrcA and the counter with N, then enter SHIFT.
REQ-022 Each SHIFT cycle SHALL shift the register by one bit and decrement the counter; when the counter reaches 0, the block SHALL load ALUResult and enter DONE, giving a latency of N+1 cycles.
REQ-023 ALUResult SHALL update only on the transition into DONE and SHALL otherwise hold its value.
REQ-024 out_valid SHALL be 1 exactly when the state is DONE.
REQ-025 In DONE, the block SHALL return to IDLE on the edge where out_valid && out_ready; no new request SHALL be accepted on that same edge.
REQ-026 While in DONE with out_ready = 0, the block SHALL hold ALUResult and Zero stable indefinitely.
REQ-027 in_valid SHALL be ignored in SHIFT and DONE and SHALL have no side effects.
REQ-028 out_ready SHALL be ignored outside DONE.
REQ-029 If out_ready is held at 1, out_valid SHALL be a single-cycle pulse per request.

Reset
REQ-030 While reset = 1 at a rising edge, the block SHALL set the state to IDLE, the counter to 0, the shift register to 0 and ALUResult to 0.
REQ-031 After a reset edge, the block SHALL present in_ready = 1, out_valid = 0, ALUResult = 0x00000000 and Zero = 1.
REQ-032 A reset asserted in SHIFT or DONE SHALL discard the in-flight request and produce no out_valid for it.
REQ-033 Reset SHALL take priority over acceptance and over the out handshake on the same edge.

Verification
REQ-034 ADD with A = 0x7FFFFFFF, B = 0x00000001 -> out_valid 1 cycle after acceptance, ALUResult = 0x80000000, Zero = 0.
REQ-035 SRA with A = 0x80000000, B = 0x00000004 -> in_ready = 0 for 5 cycles, out_valid 5 cycles after acceptance, ALUResult = 0xF8000000.
REQ-036 The following single-cycle cases -> each has 1-cycle latency:
- SLT with A = 0xFFFFFFFF, B = 0x00000001 -> ALUResult = 1.
- EQUAL with A = B = 5 -> ALUResult = 1.
- SUB 5 - 5 -> ALUResult = 0, Zero = 1.
- Operation = 1111 -> ALUResult = 0.
REQ-037 SLL with A = 0x00000001, B = 0x00000020 (amount 0) -> ALUResult = 0x00000001 with 1-cycle latency; SLL by 31 -> 0x80000000 with 32-cycle latency.
REQ-038 Backpressure: out_ready = 0 for 3 cycles in DONE, with in_valid pulsed and SrcA changed -> ALUResult held, no new acceptance; out_ready = 1 -> IDLE on the next edge.
REQ-039 Reset asserted mid-SHIFT of an SLL by 31 -> next cycle state is IDLE, in_ready = 1, out_valid = 0, ALUResult = 0, and no result ever emitted for that request.

Source files
------------

// File: rtl/iterative_alu.sv
// Iterative ALU: single-cycle logic/arithmetic ops, shifts performed one bit per cycle.
// The result is held in a registered output until the consumer accepts it.
module iterative_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero,
  output logic [1:0]            dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // in_ready is high only in IDLE and out_valid only in DONE, so the two never overlap.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;

  state_t                state;
  logic [4:0]            cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [1:0]            shift_kind;

  logic                  is_shift;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] imm_result;
  logic [DATA_WIDTH-1:0] shift_next;

  assign shamt    = SrcB[4:0];
  assign is_shift = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);

  // Shifts only reach this path with a zero amount, where the result is SrcA unchanged.
  always_comb begin
    imm_result = '0;
    case (Operation)
      OP_AND: imm_result = SrcA & SrcB;
      OP_SUB: imm_result = SrcA - SrcB;
      OP_ADD: imm_result = SrcA + SrcB;
      OP_OR:  imm_result = SrcA | SrcB;
      OP_XOR: imm_result = SrcA ^ SrcB;
      OP_SLT: imm_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_EQ:  imm_result = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
      OP_SLL, OP_SRL, OP_SRA: imm_result = SrcA;
      default: imm_result = '0;
    endcase
  end

  // shift_kind holds Operation[1:0] of the accepted shift: 01 SLL, 10 SRL, 11 SRA.
  always_comb begin
    shift_next = shreg;
    case (shift_kind)
      2'b01:   shift_next = {shreg[DATA_WIDTH-2:0], 1'b0};
      2'b10:   shift_next = {1'b0, shreg[DATA_WIDTH-1:1]};
      2'b11:   shift_next = {shreg[DATA_WIDTH-1], shreg[DATA_WIDTH-1:1]};
      default: shift_next = shreg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      shift_kind <= '0;
      ALUResult  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_kind <= Operation[1:0];
            if (is_shift && (shamt != 5'd0)) begin
              shreg <= SrcA;
              cnt   <= shamt;
              state <= SHIFT;
            end else begin
              ALUResult <= imm_result;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          shreg <= shift_next;
          cnt   <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            ALUResult <= shift_next;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign Zero      = (ALUResult == '0);
  assign dbg_state = state;

endmodule

// File: tb/tb_iterative_alu.sv
// Bench for iterative_alu: directed corner cases plus randomized ops against an
// arithmetic reference model, with backpressure and mid-operation reset scenarios.
module tb_iterative_alu;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic [1:0]  dbg_state;

  int n_cmp;
  int n_err;
  logic [31:0] exp_q[$];

  iterative_alu #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a - b;
      4'd2:  return a + b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  return (a == b) ? 32'd1 : 32'd0;
      4'd9:  return a << sh;
      4'd10: return a >> sh;
      4'd11: return 32'($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    if ((op == 4'd9 || op == 4'd10 || op == 4'd11) && sh != 0) return sh + 1;
    return 1;
  endfunction

  // Driver: issue one request in IDLE, then track it through to its result.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int exp_lat;
    int lat;
    exp_lat = ref_lat(op, b);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL idle_ready op=%h got=%b want=1", op, in_ready);
    end
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    exp_q.push_back(ref_alu(op, a, b));
    @(posedge clk); #1;
    in_valid  = 1'b0;
    Operation = 4'($urandom);
    SrcA      = $urandom;
    SrcB      = $urandom;
    lat = 1;
    while (out_valid !== 1'b1 && lat <= 40) begin
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL busy_ready op=%h cycle=%0d got=%b want=0", op, lat, in_ready);
      end
      @(posedge clk); #1;
      lat++;
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL timeout op=%h a=%h b=%h got out_valid=%b want=1", op, a, b, out_valid);
    end
    n_cmp++;
    if (lat != exp_lat) begin
      n_err++;
      $display("FAIL latency op=%h a=%h b=%h got=%0d want=%0d", op, a, b, lat, exp_lat);
    end
    n_cmp++;
    if (ALUResult !== exp) begin
      n_err++;
      $display("FAIL result op=%h a=%h b=%h got=%h want=%h", op, a, b, ALUResult, exp);
    end
    n_cmp++;
    if (Zero !== (exp == 32'd0)) begin
      n_err++;
      $display("FAIL zero op=%h got=%b want=%b", op, Zero, (exp == 32'd0));
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL done_ready op=%h got=%b want=0", op, in_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL pulse op=%h got out_valid=%b in_ready=%b want 0/1", op, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      in_valid = 1'($urandom);
      Operation = 4'd2; SrcA = $urandom; SrcB = $urandom;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || ALUResult !== 32'd0 || Zero !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state got in_ready=%b out_valid=%b result=%h zero=%b want 1/0/0/1",
               in_ready, out_valid, ALUResult, Zero);
    end
    reset = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    run_op(4'b1011, 32'h8000_0000, 32'h0000_0004);
    run_op(4'b0101, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op(4'b1000, 32'd5, 32'd5);
    run_op(4'b0001, 32'd5, 32'd5);
    run_op(4'b1111, $urandom, $urandom);
    run_op(4'b1001, 32'h0000_0001, 32'h0000_0020);
    run_op(4'b1001, 32'h0000_0001, 32'd31);
    run_op(4'b1010, 32'h8000_0000, 32'hFFFF_FFE1);
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) op = 4'($urandom_range(9, 11));
      else op = 4'($urandom_range(0, 15));
      run_op(op, $urandom, $urandom);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    int lat;
    out_ready = 1'b0;
    exp = ref_alu(4'd4, 32'h1234_5678, 32'h0F0F_0F0F);
    Operation = 4'd4; SrcA = 32'h1234_5678; SrcB = 32'h0F0F_0F0F; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; Operation = 4'd2; SrcA = $urandom; SrcB = $urandom;
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || ALUResult !== exp) begin
        n_err++;
        $display("FAIL hold cycle=%0d got valid=%b ready=%b result=%h want 1/0/%h",
                 i, out_valid, in_ready, ALUResult, exp);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL release got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    logic seen;
    Operation = 4'b1001; SrcA = 32'h0000_0001; SrcB = 32'd31; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || ALUResult !== 32'd0 || Zero !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset got ready=%b valid=%b result=%h zero=%b want 1/0/0/1",
               in_ready, out_valid, ALUResult, Zero);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL ghost_result got out_valid seen=%b want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    run_op(4'd2, 32'hFFFF_FFFF, 32'd1);
    run_op(4'd11, 32'h7000_0000, 32'd3);
    run_op(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
    run_op(4'd3, 32'd0, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    Operation = 4'd0;
    SrcA = 32'd0;
    SrcB = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
